// File: rtl/x_mem_player_if.sv
// rtl/x_mem_player_if.sv - control, memory read port and DAC sample bus of x_mem_player
// master = the player, slave = the controller/memory/DAC side.
interface x_mem_player_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 6,
  parameter int DIV_W  = 16
);
  logic              i_start;
  logic              i_stop;
  logic              i_loop;
  logic [ADDR_W-1:0] i_len;
  logic [DIV_W-1:0]  i_div;
  logic [ADDR_W-1:0] o_addr;
  logic              o_rd_en;
  logic [DATA_W-1:0] i_rdata;
  logic [DATA_W-1:0] o_bin;
  logic              o_bin_valid;
  logic              o_busy;
  logic              o_done;

  modport master (
    input  i_start, i_stop, i_loop, i_len, i_div, i_rdata,
    output o_addr, o_rd_en, o_bin, o_bin_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_stop, i_loop, i_len, i_div, i_rdata,
    input  o_addr, o_rd_en, o_bin, o_bin_valid, o_busy, o_done
  );
endinterface

// File: rtl/x_mem_player.sv
// rtl/x_mem_player.sv - streams len samples from sample memory to the DAC at a fixed period
// Optional X_MEM_PLAYER_MUTE_EN parks o_bin at mid-scale whenever playback is not active.
module x_mem_player #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 6,
  parameter int DIV_W  = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  x_mem_player_if.master  bus
);
  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_PLAY} state_t;

`ifdef X_MEM_PLAYER_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  localparam logic [DATA_W-1:0] MID     = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] BIN_RST = MUTE ? MID : '0;
  localparam logic [DIV_W-1:0]  DIV_MIN = DIV_W'(2);
  // Period counter value just before the edge that captures read data.
  localparam logic [DIV_W-1:0]  CAP_CNT = DIV_W'(2);

  state_t            state_q, state_n;
  logic [DIV_W-1:0]  cnt_q, cnt_n;
  logic [DIV_W-1:0]  div_q, div_n;
  logic [ADDR_W-1:0] len_m1_q, len_m1_n;
  logic              loop_q, loop_n;
  logic              pend_q, pend_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic              rd_en_q, rd_en_n;
  logic [DATA_W-1:0] bin_q, bin_n;
  logic              bin_valid_q, bin_valid_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      div_q       <= '0;
      len_m1_q    <= '0;
      loop_q      <= 1'b0;
      pend_q      <= 1'b0;
      addr_q      <= '0;
      rd_en_q     <= 1'b0;
      bin_q       <= BIN_RST;
      bin_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      div_q       <= div_n;
      len_m1_q    <= len_m1_n;
      loop_q      <= loop_n;
      pend_q      <= pend_n;
      addr_q      <= addr_n;
      rd_en_q     <= rd_en_n;
      bin_q       <= bin_n;
      bin_valid_q <= bin_valid_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
    end
  end

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    div_n       = div_q;
    len_m1_n    = len_m1_q;
    loop_n      = loop_q;
    pend_n      = pend_q;
    addr_n      = addr_q;
    rd_en_n     = 1'b0;
    bin_n       = bin_q;
    bin_valid_n = 1'b0;
    busy_n      = busy_q;
    done_n      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.i_start && !bus.i_stop) begin
          state_n  = S_PRIME;
          cnt_n    = '0;
          div_n    = (bus.i_div < DIV_MIN) ? DIV_MIN : bus.i_div;
          // len=0 wraps to all-ones, i.e. a full 2^ADDR_W pass.
          len_m1_n = bus.i_len - ADDR_W'(1);
          loop_n   = bus.i_loop;
          addr_n   = '0;
          rd_en_n  = 1'b1;
          pend_n   = 1'b1;
          busy_n   = 1'b1;
        end
      end
      default: begin
        if (bus.i_stop) begin
          state_n = S_IDLE;
          busy_n  = 1'b0;
          pend_n  = 1'b0;
          if (MUTE) begin
            bin_n       = MID;
            bin_valid_n = 1'b1;
          end
        end else begin
          cnt_n = (cnt_q == div_q) ? '0 : cnt_q + DIV_W'(1);
          if (cnt_q == CAP_CNT) begin
            if (pend_q) begin
              bin_n       = bus.i_rdata;
              bin_valid_n = 1'b1;
              pend_n      = 1'b0;
              state_n     = S_PLAY;
            end else begin
              // No read outstanding: the last sample has had its full period.
              state_n = S_IDLE;
              busy_n  = 1'b0;
              done_n  = 1'b1;
              if (MUTE) begin
                bin_n       = MID;
                bin_valid_n = 1'b1;
              end
            end
          end
          // With D=2 this coincides with a capture, so it must override pend_n.
          if (cnt_q == div_q && (loop_q || addr_q != len_m1_q)) begin
            addr_n  = (addr_q == len_m1_q) ? '0 : addr_q + ADDR_W'(1);
            rd_en_n = 1'b1;
            pend_n  = 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.o_addr      = addr_q;
  assign bus.o_rd_en     = rd_en_q;
  assign bus.o_bin       = bin_q;
  assign bus.o_bin_valid = bin_valid_q;
  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
endmodule

// File: tb/tb_x_mem_player.sv
// tb/tb_x_mem_player.sv - self-checking bench for x_mem_player
// Expectations come from per-edge arithmetic on (len, period, loop, stop edge).
module tb_x_mem_player;
  localparam int ADDR_W = 11;
  localparam int DATA_W = 6;
  localparam int DIV_W  = 16;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef X_MEM_PLAYER_MUTE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  localparam int MID     = 1 << (DATA_W - 1);
  localparam int BIN_RST = MUTE ? MID : 0;
  localparam int NEVER   = 32'h3fffffff;

  typedef struct {
    int busy; int rd; int addr; int valid; int bin; int done;
  } exp_t;

  typedef struct {
    int len; int div; int lp; int stop_at; int exp_samples; int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  x_mem_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus ();

  x_mem_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) if (bus.o_rd_en) bus.i_rdata <= mem[bus.o_addr];

  int n_cmp  = 0;
  int n_fail = 0;
  int prev_bin;
  vec_t tbl [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int addr_at(int n, int L, int P, int lp);
    int k = n / P;
    if (lp != 0) return k % L;
    return (k < L) ? k : L - 1;
  endfunction

  function automatic int bin_at(int n, int L, int P, int prev);
    if (n < 3) return prev;
    return int'(mem[((n - 3) / P) % L]);
  endfunction

  // Outputs observed after edge n, where edge 0 accepted the start.
  function automatic exp_t model(int n, int L, int P, int lp, int s, int prev);
    exp_t e;
    int endn = (lp != 0) ? NEVER : 3 + L * P;
    if (s > 0 && s <= endn && n >= s) begin
      e.busy = 0; e.rd = 0; e.done = 0;
      e.valid = (MUTE && n == s) ? 1 : 0;
      e.addr  = addr_at(s - 1, L, P, lp);
      e.bin   = MUTE ? MID : bin_at(s - 1, L, P, prev);
    end else if (n >= endn) begin
      e.busy = 0; e.rd = 0;
      e.done  = (n == endn) ? 1 : 0;
      e.valid = (MUTE && n == endn) ? 1 : 0;
      e.addr  = L - 1;
      e.bin   = MUTE ? MID : int'(mem[L - 1]);
    end else begin
      e.busy  = 1;
      e.done  = 0;
      e.rd    = (n % P == 0 && (lp != 0 || n / P < L)) ? 1 : 0;
      e.addr  = addr_at(n, L, P, lp);
      e.valid = (n >= 3 && (n - 3) % P == 0) ? 1 : 0;
      e.bin   = bin_at(n, L, P, prev);
    end
    return e;
  endfunction

  task automatic run_case(input int cid, input int len_f, input int div, input int lp,
                          input int s, output int samples, output int dones);
    int L    = (len_f == 0) ? DEPTH : len_f;
    int P    = ((div < 2) ? 2 : div) + 1;
    int endn = (lp != 0) ? NEVER : 3 + L * P;
    int last = (s > 0 && s <= endn) ? s + 2 : endn + 2;
    exp_t e;
    samples = 0;
    dones   = 0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_stop  = 1'b0;
    bus.i_len   = ADDR_W'(len_f);
    bus.i_div   = DIV_W'(div);
    bus.i_loop  = (lp != 0);
    @(posedge clk);
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      e = model(n, L, P, lp, s, prev_bin);
      check($sformatf("c%0d n%0d busy", cid, n),  32'(bus.o_busy),      32'(e.busy));
      check($sformatf("c%0d n%0d rd_en", cid, n), 32'(bus.o_rd_en),     32'(e.rd));
      check($sformatf("c%0d n%0d addr", cid, n),  32'(bus.o_addr),      32'(e.addr));
      check($sformatf("c%0d n%0d valid", cid, n), 32'(bus.o_bin_valid), 32'(e.valid));
      check($sformatf("c%0d n%0d bin", cid, n),   32'(bus.o_bin),       32'(e.bin));
      check($sformatf("c%0d n%0d done", cid, n),  32'(bus.o_done),      32'(e.done));
      if (bus.o_bin_valid && bus.o_busy) samples++;
      if (bus.o_done) dones++;
      // Random start pulses and config churn only while the player is certainly busy.
      bus.i_stop  = (n + 1 == s);
      bus.i_start = ((s == 0 || n + 1 < s) && n + 1 < endn) ? ($urandom_range(0, 3) == 0) : 1'b0;
      bus.i_len   = ADDR_W'($urandom);
      bus.i_div   = DIV_W'($urandom);
      bus.i_loop  = 1'($urandom);
    end
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
    prev_bin = e.bin;
  endtask

  initial begin
    int samples, dones;
    rst = 1'b1;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_loop = 1'b0;
    bus.i_len = '0; bus.i_div = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DATA_W'((i * 13 + 7) % 64);
    mem[0] = 6'd5; mem[1] = 6'd10; mem[2] = 6'd20; mem[3] = 6'd40;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset busy",  32'(bus.o_busy),      0);
    check("reset rd_en", 32'(bus.o_rd_en),     0);
    check("reset addr",  32'(bus.o_addr),      0);
    check("reset bin",   32'(bus.o_bin),       BIN_RST);
    check("reset valid", 32'(bus.o_bin_valid), 0);
    check("reset done",  32'(bus.o_done),      0);
    rst = 1'b0;
    prev_bin = BIN_RST;

    // start+stop together in idle must be ignored
    bus.i_start = 1'b1; bus.i_stop = 1'b1; bus.i_len = 11'd4; bus.i_div = 16'd3;
    @(negedge clk);
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("start_stop_idle busy",  32'(bus.o_busy),  0);
      check("start_stop_idle rd_en", 32'(bus.o_rd_en), 0);
      @(negedge clk);
    end

    // reset asserted mid-playback for one cycle
    bus.i_start = 1'b1; bus.i_loop = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b0;
    repeat (6) @(negedge clk);
    check("midplay pre busy", 32'(bus.o_busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy",  32'(bus.o_busy),      0);
    check("midrst rd_en", 32'(bus.o_rd_en),     0);
    check("midrst addr",  32'(bus.o_addr),      0);
    check("midrst bin",   32'(bus.o_bin),       BIN_RST);
    check("midrst valid", 32'(bus.o_bin_valid), 0);
    check("midrst done",  32'(bus.o_done),      0);
    prev_bin = BIN_RST;

    //            len   div lp stop samples done
    tbl[0] = '{   4,    3,  0,  0,   4,     1};  // one-shot, done after E19
    tbl[1] = '{   3,    2,  1, 20,   6,     0};  // loop wrap, stop after 6 captures
    tbl[2] = '{   0,    0,  0,  0, 2048,    1};  // clamp to P=3, full 2048 pass
    tbl[3] = '{   2,    1,  0,  9,   2,     0};  // stop coincident with completion
    tbl[4] = '{   1,    5,  0,  0,   1,     1};  // single sample, P=6
    tbl[5] = '{   5,    4,  0, 12,   2,     0};  // stop discards pending capture
    tbl[6] = '{   1,    2,  1, 10,   3,     0};  // loop of length 1
    tbl[7] = '{   4,    3,  0,  1,   0,     0};  // stop right after start
    tbl[8] = '{   3,    0,  1,  8,   2,     0};  // loop with clamped divider
    tbl[9] = '{   4,    3,  0,  0,   4,     1};  // back-to-back restart after done
    for (int i = 0; i < 10; i++) begin
      run_case(i, tbl[i].len, tbl[i].div, tbl[i].lp, tbl[i].stop_at, samples, dones);
      check($sformatf("tbl%0d samples", i), 32'(samples), 32'(tbl[i].exp_samples));
      check($sformatf("tbl%0d done", i),    32'(dones),   32'(tbl[i].exp_done));
    end

    for (int r = 0; r < 25; r++) begin
      int len = $urandom_range(1, 12);
      int div = $urandom_range(0, 5);
      int lp  = $urandom_range(0, 1);
      int P   = ((div < 2) ? 2 : div) + 1;
      int s;
      for (int i = 0; i < 16; i++) mem[i] = DATA_W'($urandom);
      if (lp != 0) s = $urandom_range(1, 2 * len * P + 5);
      else s = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3 + len * P + 2);
      run_case(100 + r, len, div, lp, s, samples, dones);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
